vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter.sv | 113 +++++++++++
 tb/tb_vram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, the CPU/loader port uses
// free slots, and a 2-stage read tag routes each RAM response to its requester.
module vram_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 800,
    parameter int WAIT_W     = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic [DATA_W-1:0] o_vid_data,
    output logic              o_vid_valid,
    input  logic              i_cpu_valid,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ready,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_rvalid,
    output logic              o_cpu_starved,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_MAX);

    logic vid_gnt;
    logic cpu_gnt;

    tag_t tag1_reg;
    tag_t tag1_next;

    logic [DATA_W-1:0] vid_data_reg;
    logic [DATA_W-1:0] cpu_data_reg;
    logic              vid_valid_reg;
    logic              cpu_valid_reg;

    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;
    logic              starved_reg;

    // Scanout owns the RAM whenever it asks; the CPU only gets leftover slots.
    assign vid_gnt = i_vid_req;
    assign cpu_gnt = i_cpu_valid & ~i_vid_req & ~i_reset;

    assign o_cpu_ready = cpu_gnt;
    assign o_ram_addr  = vid_gnt ? i_vid_addr : i_cpu_addr;
    assign o_ram_we    = cpu_gnt & i_cpu_we;
    assign o_ram_wdata = i_cpu_wdata;

    always_comb begin
        tag1_next = TAG_NONE;
        if (vid_gnt) begin
            tag1_next = TAG_VID;
        end else if (cpu_gnt && !i_cpu_we) begin
            tag1_next = TAG_CPU;
        end
    end

    // Wait counter only runs while a CPU request is actually being refused.
    always_comb begin
        wait_next = wait_reg;
        if (!i_cpu_valid || cpu_gnt) begin
            wait_next = '0;
        end else if (wait_reg != {WAIT_W{1'b1}}) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tag1_reg      <= TAG_NONE;
            vid_data_reg  <= '0;
            cpu_data_reg  <= '0;
            vid_valid_reg <= 1'b0;
            cpu_valid_reg <= 1'b0;
            wait_reg      <= '0;
            starved_reg   <= 1'b0;
        end else begin
            tag1_reg <= tag1_next;

            // Stage 2: RAM data for the stage-1 tag arrives now.
            vid_valid_reg <= (tag1_reg == TAG_VID);
            cpu_valid_reg <= (tag1_reg == TAG_CPU);
            if (tag1_reg == TAG_VID) begin
                vid_data_reg <= i_ram_rdata;
            end
            if (tag1_reg == TAG_CPU) begin
                cpu_data_reg <= i_ram_rdata;
            end

            wait_reg    <= wait_next;
            starved_reg <= (wait_next >= STARVE_TH);
        end
    end

    assign o_vid_data    = vid_data_reg;
    assign o_vid_valid   = vid_valid_reg;
    assign o_cpu_rdata   = cpu_data_reg;
    assign o_cpu_rvalid  = cpu_valid_reg;
    assign o_cpu_starved = starved_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected read
// responses with their due cycle; a negedge monitor pops and compares them.
module tb_vram_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_vid_req;
    logic [ADDR_W-1:0] i_vid_addr;
    logic [DATA_W-1:0] o_vid_data;
    logic              o_vid_valid;
    logic              i_cpu_valid;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_ready;
    logic [DATA_W-1:0] o_cpu_rdata;
    logic              o_cpu_rvalid;
    logic              o_cpu_starved;
    logic [ADDR_W-1:0] o_ram_addr;
    logic              o_ram_we;
    logic [DATA_W-1:0] o_ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(8), .WAIT_W(12)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr),
        .o_vid_data(o_vid_data), .o_vid_valid(o_vid_valid),
        .i_cpu_valid(i_cpu_valid), .i_cpu_we(i_cpu_we),
        .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
        .o_cpu_ready(o_cpu_ready), .o_cpu_rdata(o_cpu_rdata),
        .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_starved(o_cpu_starved),
        .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // VRAM model: synchronous read, preloaded with mem[a] = a[7:0] on the first edge.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int a = 0; a < (1 << ADDR_W); a++) mem[a] <= a[7:0];
            preloaded <= 1'b1;
        end else if (o_ram_we) begin
            mem[o_ram_addr] <= o_ram_wdata;
        end
        ram_rdata <= mem[o_ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] due;
    } exp_t;

    exp_t vid_q[$];
    exp_t cpu_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected or missing response (cycle %0d)", name, cyc);
    endtask

    // Monitor: every valid pulse must match the oldest expectation and its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (vid_q.size() != 0 && vid_q[0].due < cyc) begin
            report_fail("vid_missing");
            e = vid_q.pop_front();
        end
        if (cpu_q.size() != 0 && cpu_q[0].due < cyc) begin
            report_fail("cpu_missing");
            e = cpu_q.pop_front();
        end
        if (o_vid_valid === 1'b1) begin
            if (vid_q.size() == 0) begin
                report_fail("vid_spurious");
            end else begin
                e = vid_q.pop_front();
                chk("vid_data", o_vid_data, e.data);
                chk("vid_latency", cyc, e.due);
                $display("vid resp cycle %0d data 0x%0h", cyc, o_vid_data);
            end
        end
        if (o_cpu_rvalid === 1'b1) begin
            if (cpu_q.size() == 0) begin
                report_fail("cpu_spurious");
            end else begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", o_cpu_rdata, e.data);
                chk("cpu_latency", cyc, e.due);
                $display("cpu resp cycle %0d data 0x%0h", cyc, o_cpu_rdata);
            end
        end
    end

    // Called at posedge+1: inputs apply to this cycle, response due two cycles later.
    task automatic drive(input logic vr, input logic [ADDR_W-1:0] va,
                         input logic cv, input logic cwe, input logic [ADDR_W-1:0] ca,
                         input logic [DATA_W-1:0] cwd, input logic exp_rdy, input logic exp_stv);
        i_vid_req   = vr;
        i_vid_addr  = va;
        i_cpu_valid = cv;
        i_cpu_we    = cwe;
        i_cpu_addr  = ca;
        i_cpu_wdata = cwd;
        @(negedge clk);
        chk("cpu_ready", o_cpu_ready, exp_rdy);
        chk("ram_we", o_ram_we, exp_rdy & cwe);
        chk("starved", o_cpu_starved, exp_stv);
        if (vr) chk("ram_addr_vid", o_ram_addr, va);
        else if (cv) chk("ram_addr_cpu", o_ram_addr, ca);
        @(posedge clk);
        #1;
    endtask

    task automatic push_vid(input logic [7:0] d);
        vid_q.push_back({d, 32'(cyc + 2)});
    endtask

    task automatic push_cpu(input logic [7:0] d);
        cpu_q.push_back({d, 32'(cyc + 2)});
    endtask

    task automatic vid(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        push_vid(d);
        drive(1'b1, a, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic cpu_rd(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        push_cpu(d);
        drive(1'b0, '0, 1'b1, 1'b0, a, '0, 1'b1, 1'b0);
    endtask

    task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        drive(1'b0, '0, 1'b1, 1'b1, a, d, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Reset with a CPU write pending: it must be neither accepted nor written.
        i_reset     = 1'b1;
        i_vid_req   = 1'b0;
        i_vid_addr  = '0;
        i_cpu_valid = 1'b1;
        i_cpu_we    = 1'b1;
        i_cpu_addr  = 13'h010;
        i_cpu_wdata = 8'hEE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", o_cpu_ready, 1'b0);
        chk("rst_ram_we", o_ram_we, 1'b0);
        chk("rst_vid_valid", o_vid_valid, 1'b0);
        chk("rst_cpu_rvalid", o_cpu_rvalid, 1'b0);
        chk("rst_vid_data", o_vid_data, 8'h00);
        chk("rst_cpu_rdata", o_cpu_rdata, 8'h00);
        chk("rst_starved", o_cpu_starved, 1'b0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;

        // Continuous scanout, no gaps; address 0x10 proves the reset-time write was blocked.
        for (int a = 0; a < 8; a++) vid(13'(a), 8'(a));
        vid(13'h010, 8'h10);
        idle(3);

        // CPU write then read-back of the same address.
        cpu_wr(13'h100, 8'h5A);
        cpu_rd(13'h100, 8'h5A);
        idle(3);

        // CPU read held off by 12 scanout cycles; starvation flag after 8 wait cycles.
        for (int k = 0; k < 12; k++) begin
            push_vid(8'(8'h20 + k));
            drive(1'b1, 13'(13'h020 + k), 1'b1, 1'b0, 13'h1234, 8'h00, 1'b0, (k >= 8));
        end
        push_cpu(8'h34);
        drive(1'b0, '0, 1'b1, 1'b0, 13'h1234, 8'h00, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);

        // Interleaved scanout / CPU traffic, back-to-back CPU accesses, top address.
        vid(13'h040, 8'h40);
        cpu_rd(13'h041, 8'h41);
        vid(13'h042, 8'h42);
        cpu_rd(13'h043, 8'h43);
        cpu_rd(13'h044, 8'h44);
        cpu_wr(13'h055, 8'h77);
        cpu_rd(13'h055, 8'h77);
        vid(13'h1FFF, 8'hFF);
        vid(13'h100, 8'h5A);
        idle(3);

        // Reset one cycle after a CPU read transfer: that read must never complete.
        vid(13'h0A5, 8'hA5);
        drive(1'b0, '0, 1'b1, 1'b0, 13'h1234, 8'h00, 1'b1, 1'b0);
        i_reset = 1'b1;
        idle(2);
        chk("midrst_vid_data", o_vid_data, 8'h00);
        chk("midrst_cpu_rdata", o_cpu_rdata, 8'h00);
        chk("midrst_vid_valid", o_vid_valid, 1'b0);
        chk("midrst_cpu_rvalid", o_cpu_rvalid, 1'b0);
        chk("midrst_starved", o_cpu_starved, 1'b0);
        i_reset = 1'b0;
        idle(4);

        chk("vid_queue_drained", vid_q.size(), 0);
        chk("cpu_queue_drained", cpu_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
